// File: rtl/double_threshold_unit.sv
// Canny double-threshold stage: buffers a frame, finds its maximum, derives
// high/low thresholds from it and writes a 0 / weak / strong map for hysteresis_unit.
module double_threshold_unit #(
   parameter int         HEIGHT        = 5,
   parameter int         WIDTH         = 5,
   parameter logic [7:0] WEAK_PIXEL    = 8'd75,
   parameter logic [7:0] STRONG_PIXEL  = 8'd255,
   parameter logic [7:0] HIGH_RATIO_Q8 = 8'd23,
   parameter logic [7:0] LOW_RATIO_Q8  = 8'd13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] img [0:HEIGHT*WIDTH-1],
   output logic [7:0] res [0:HEIGHT*WIDTH-1],
   output logic [7:0] high_thr,
   output logic [7:0] low_thr,
   output logic       done
);

   localparam int IMG_SIZE = HEIGHT * WIDTH;
   localparam int IDX_W    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_SCAN_MAX = 3'd1,
      S_CALC     = 3'd2,
      S_CLASSIFY = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t             state_q,    state_d;
   logic [IDX_W-1:0]   idx_q,      idx_d;
   logic [7:0]         max_q,      max_d;
   logic [7:0]         high_thr_q, high_thr_d;
   logic [7:0]         low_thr_q,  low_thr_d;
   logic               done_q,     done_d;
   logic [7:0]         frame_q [0:IMG_SIZE-1];
   logic [7:0]         frame_d [0:IMG_SIZE-1];
   logic [7:0]         res_q   [0:IMG_SIZE-1];
   logic [7:0]         res_d   [0:IMG_SIZE-1];

   logic               last_s;
   logic               accept_s;
   logic [15:0]        high_prod_s;
   logic [15:0]        low_prod_s;
   logic [7:0]         high_calc_s;
   logic [7:0]         low_calc_s;

   function automatic logic [7:0] classify_pixel(input logic [7:0] pix,
                                                 input logic [7:0] hi,
                                                 input logic [7:0] lo);
      logic [7:0] code;
      if (pix == 8'd0) begin
         code = 8'd0;
      end else if (pix >= hi) begin
         code = STRONG_PIXEL;
      end else if (pix >= lo) begin
         code = WEAK_PIXEL;
      end else begin
         code = 8'd0;
      end
      return code;
   endfunction

   assign last_s      = (idx_q == IDX_W'(IMG_SIZE - 1));
   assign high_prod_s = {8'd0, max_q} * {8'd0, HIGH_RATIO_Q8};
   assign high_calc_s = high_prod_s[15:8];
   assign low_prod_s  = {8'd0, high_calc_s} * {8'd0, LOW_RATIO_Q8};
   assign low_calc_s  = low_prod_s[15:8];

   // The first DONE cycle only publishes done, so a held enable re-accepts one cycle later.
   assign accept_s = enable && ((state_q == S_IDLE) || ((state_q == S_DONE) && done_q));

   // Next-state and datapath update for the capture / scan / calc / classify sequence.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      max_d      = max_q;
      high_thr_d = high_thr_q;
      low_thr_d  = low_thr_q;
      done_d     = done_q;
      frame_d    = frame_q;
      res_d      = res_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               state_d = S_SCAN_MAX;
               frame_d = img;
               for (int i = 0; i < IMG_SIZE; i++) begin
                  res_d[i] = 8'd0;
               end
               done_d  = 1'b0;
               max_d   = 8'd0;
               idx_d   = {IDX_W{1'b0}};
            end else if (state_q == S_DONE) begin
               done_d  = 1'b1;
            end else begin
               done_d  = 1'b0;
            end
         end
         S_SCAN_MAX: begin
            if (frame_q[idx_q] > max_q) begin
               max_d = frame_q[idx_q];
            end else begin
               max_d = max_q;
            end
            if (last_s) begin
               idx_d   = {IDX_W{1'b0}};
               state_d = S_CALC;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         S_CALC: begin
            high_thr_d = high_calc_s;
            low_thr_d  = low_calc_s;
            state_d    = S_CLASSIFY;
         end
         S_CLASSIFY: begin
            res_d[idx_q] = classify_pixel(frame_q[idx_q], high_thr_q, low_thr_q);
            if (last_s) begin
               idx_d   = {IDX_W{1'b0}};
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= {IDX_W{1'b0}};
         max_q      <= 8'd0;
         high_thr_q <= 8'd0;
         low_thr_q  <= 8'd0;
         done_q     <= 1'b0;
         for (int i = 0; i < IMG_SIZE; i++) begin
            frame_q[i] <= 8'd0;
            res_q[i]   <= 8'd0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         max_q      <= max_d;
         high_thr_q <= high_thr_d;
         low_thr_q  <= low_thr_d;
         done_q     <= done_d;
         frame_q    <= frame_d;
         res_q      <= res_d;
      end
   end

   assign res      = res_q;
   assign high_thr = high_thr_q;
   assign low_thr  = low_thr_q;
   assign done     = done_q;

endmodule

// File: tb/tb_double_threshold_unit.sv
// Table-driven bench for double_threshold_unit: two instances (ratios 128/128 and
// defaults) share stimulus; expected frames go through a scoreboard queue.
module tb_double_threshold_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] img   [0:24];
   logic [7:0] res_a [0:24];
   logic [7:0] res_b [0:24];
   logic [7:0] hi_a, lo_a, hi_b, lo_b;
   logic       done_a, done_b;

   typedef struct {
      int         n;
      int         idx [5];
      logic [7:0] val [5];
      logic [7:0] ra  [5];
      logic [7:0] rb  [5];
      logic [7:0] hi_a, lo_a, hi_b, lo_b;
   } vec_t;

   typedef struct {
      logic [7:0] hi_a, lo_a, hi_b, lo_b;
      logic [7:0] ra [0:24];
      logic [7:0] rb [0:24];
   } exp_t;

   vec_t tbl [0:4];
   exp_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   double_threshold_unit #(.HIGH_RATIO_Q8(8'd128), .LOW_RATIO_Q8(8'd128)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .img(img),
      .res(res_a), .high_thr(hi_a), .low_thr(lo_a), .done(done_a)
   );

   double_threshold_unit dut_b (
      .clk(clk), .reset(reset), .enable(enable), .img(img),
      .res(res_b), .high_thr(hi_b), .low_thr(lo_b), .done(done_b)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_res(input string name, input logic [7:0] act [0:24],
                            input logic [7:0] exp [0:24]);
      int bad = -1;
      n_cmp++;
      for (int i = 24; i >= 0; i--) begin
         if (act[i] !== exp[i]) bad = i;
      end
      if (bad >= 0) begin
         n_bad++;
         $display("FAIL %s: res[%0d] got %0d, expected %0d", name, bad, act[bad], exp[bad]);
      end
   endtask

   task automatic set_thr(input int k, input int ha, input int la, input int hb, input int lb);
      tbl[k].n    = 0;
      tbl[k].hi_a = 8'(ha);
      tbl[k].lo_a = 8'(la);
      tbl[k].hi_b = 8'(hb);
      tbl[k].lo_b = 8'(lb);
   endtask

   task automatic add_pix(input int k, input int idx, input int val, input int ra, input int rb);
      int s = tbl[k].n;
      tbl[k].idx[s] = idx;
      tbl[k].val[s] = 8'(val);
      tbl[k].ra[s]  = 8'(ra);
      tbl[k].rb[s]  = 8'(rb);
      tbl[k].n      = s + 1;
   endtask

   task automatic load_img(input int k);
      for (int i = 0; i < 25; i++) img[i] = 8'd0;
      for (int s = 0; s < tbl[k].n; s++) img[tbl[k].idx[s]] = tbl[k].val[s];
   endtask

   task automatic push_exp(input int k);
      exp_t e;
      e.hi_a = tbl[k].hi_a;
      e.lo_a = tbl[k].lo_a;
      e.hi_b = tbl[k].hi_b;
      e.lo_b = tbl[k].lo_b;
      for (int i = 0; i < 25; i++) begin
         e.ra[i] = 8'd0;
         e.rb[i] = 8'd0;
      end
      for (int s = 0; s < tbl[k].n; s++) begin
         e.ra[tbl[k].idx[s]] = tbl[k].ra[s];
         e.rb[tbl[k].idx[s]] = tbl[k].rb[s];
      end
      sb.push_back(e);
   endtask

   // Accept edge happens at the posedge inside; returns at the following negedge.
   task automatic start_frame(input int k, input bit hold);
      @(negedge clk);
      load_img(k);
      enable = 1'b1;
      @(posedge clk);
      push_exp(k);
      @(negedge clk);
      if (!hold) enable = 1'b0;
   endtask

   // Counts cycles from the accept edge until done; optional enable pulses at p1/p2.
   task automatic wait_done(input string name, input int p1, input int p2, input int alt);
      int lat = -1;
      for (int c = 1; c <= 200 && lat < 0; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (p1 > 0 && (c == p1 - 1 || c == p2 - 1)) begin
            enable = 1'b1;
            load_img(alt);
         end else if (p1 > 0 && (c == p1 || c == p2)) begin
            enable = 1'b0;
         end
         if (done_a && done_b) lat = c;
      end
      check({name, ".latency"}, lat, 52);
   endtask

   task automatic check_frame(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s.scoreboard: got empty queue, expected an entry", name);
      end else begin
         e = sb.pop_front();
         check({name, ".hi_a"}, hi_a, e.hi_a);
         check({name, ".lo_a"}, lo_a, e.lo_a);
         check({name, ".hi_b"}, hi_b, e.hi_b);
         check({name, ".lo_b"}, lo_b, e.lo_b);
         check_res({name, ".res_a"}, res_a, e.ra);
         check_res({name, ".res_b"}, res_b, e.rb);
      end
   endtask

   task automatic check_idle(input string name);
      logic [7:0] zero [0:24];
      for (int i = 0; i < 25; i++) zero[i] = 8'd0;
      check({name, ".done_a"}, done_a, 0);
      check({name, ".done_b"}, done_b, 0);
      check({name, ".hi_a"}, hi_a, 0);
      check({name, ".lo_a"}, lo_a, 0);
      check({name, ".hi_b"}, hi_b, 0);
      check({name, ".lo_b"}, lo_b, 0);
      check_res({name, ".res_a"}, res_a, zero);
      check_res({name, ".res_b"}, res_b, zero);
   endtask

   initial begin
      exp_t drop;
      reset  = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 25; i++) img[i] = 8'd0;

      // hysteresis feed frame
      set_thr(0, 100, 50, 17, 0);
      add_pix(0, 6, 200, 255, 255);
      add_pix(0, 11, 60, 75, 255);
      // threshold boundaries
      set_thr(1, 100, 50, 17, 0);
      add_pix(1, 0, 200, 255, 255);
      add_pix(1, 1, 100, 255, 255);
      add_pix(1, 2, 99, 75, 255);
      add_pix(1, 3, 50, 75, 255);
      add_pix(1, 4, 49, 0, 255);
      // all-zero frame
      set_thr(2, 0, 0, 0, 0);
      // full-scale max with truncating ratios
      set_thr(3, 127, 63, 22, 1);
      add_pix(3, 0, 255, 255, 255);
      add_pix(3, 24, 22, 0, 255);
      add_pix(3, 12, 21, 0, 75);
      // zero thresholds with a non-zero pixel
      set_thr(4, 0, 0, 0, 0);
      add_pix(4, 7, 1, 255, 255);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      reset = 1'b0;

      for (int k = 0; k < 5; k++) begin
         start_frame(k, 1'b0);
         wait_done($sformatf("vec%0d", k), 0, 0, 0);
         check_frame($sformatf("vec%0d", k));
      end

      // enable pulses mid-frame with a different image must be ignored
      start_frame(0, 1'b0);
      wait_done("ignore_en", 10, 40, 3);
      check_frame("ignore_en");

      // back-to-back accept from DONE with enable held for two frames
      start_frame(3, 1'b1);
      check("b2b.done_a_drop", done_a, 0);
      check("b2b.done_b_drop", done_b, 0);
      check("b2b.hi_a_held", hi_a, 100);
      wait_done("b2b", 0, 0, 0);
      check_frame("b2b");
      push_exp(3);
      @(posedge clk);
      @(negedge clk);
      check("thrpt.done_a_drop", done_a, 0);
      enable = 1'b0;
      wait_done("thrpt", 0, 0, 0);
      check_frame("thrpt");

      // reset during CLASSIFY, then re-run the first frame
      start_frame(0, 1'b0);
      repeat (34) begin
         @(posedge clk);
         @(negedge clk);
      end
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_idle("mid_reset");
      drop = sb.pop_front();
      start_frame(0, 1'b0);
      wait_done("rerun", 0, 0, 0);
      check_frame("rerun");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
